// File: rtl/pwm16_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm16_gen : 16-cycle PWM, duty shadow-loaded at counter wrap, period count |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pwm16_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] q_in,
  input  logic [4:0] duty_in,
  input  logic       duty_wr,
  input  logic       en,
  output logic       pwm_out,
  output logic       period_start,
  output logic       busy,
  output logic [7:0] period_cnt
);

  localparam logic [4:0] DUTY_MAX = 5'd16;
  localparam logic [3:0] Q_LAST   = 4'd15;
  localparam logic [7:0] CNT_MAX  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t     state;
  logic [4:0] duty_sh;
  logic [4:0] duty_act;
  logic [4:0] duty_clamped;
  logic       wrap;

  assign duty_clamped = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
  assign wrap         = (q_in == Q_LAST);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      duty_sh      <= 5'd0;
      duty_act     <= 5'd0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      period_cnt   <= 8'd0;
    end else begin
      if (duty_wr)
        duty_sh <= duty_clamped;

      // Uses the pre-edge duty_act, so a shadow load at wrap only affects the next period.
      pwm_out      <= (state == RUN) && ({1'b0, q_in} < duty_act);
      period_start <= (state == RUN) && (q_in == 4'd0);

      case (state)
        IDLE: begin
          if (en)
            state <= ARM;
        end
        ARM: begin
          if (!en) begin
            state <= IDLE;
          end else if (wrap) begin
            state    <= RUN;
            duty_act <= duty_sh;
          end
        end
        RUN: begin
          if (wrap) begin
            duty_act <= duty_sh;
            if (period_cnt != CNT_MAX)
              period_cnt <= period_cnt + 8'd1;
            if (!en)
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm16_gen.sv
`default_nettype none
// tb_pwm16_gen : directed checks of pwm16_gen driven by a bench-side mod-16 counter.
module tb_pwm16_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] q_in;
  logic [4:0] duty_in;
  logic       duty_wr;
  logic       en;
  logic       pwm_out;
  logic       period_start;
  logic       busy;
  logic [7:0] period_cnt;

  logic [3:0] last_q;
  int         total  = 0;
  int         passed = 0;

  pwm16_gen dut (
    .clk          (clk),
    .reset        (reset),
    .q_in         (q_in),
    .duty_in      (duty_in),
    .duty_wr      (duty_wr),
    .en           (en),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .busy         (busy),
    .period_cnt   (period_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d (sampled q=%0d)", tag, obs, exp, last_q);
    end
  endtask

  // One clock edge; afterwards the outputs reflect q_in as sampled at that edge (last_q).
  task automatic step();
    @(posedge clk);
    #1;
    last_q = q_in;
    q_in   = q_in + 4'd1;
  endtask

  // Step while in ARM until the edge that samples q=15 (state enters RUN).
  task automatic align();
    int n = 0;
    do begin
      step();
      chk("arm_pwm", {7'd0, pwm_out}, 8'd0);
      chk("arm_pstart", {7'd0, period_start}, 8'd0);
      chk("arm_busy", {7'd0, busy}, 8'd1);
      n++;
    end while (last_q != 4'd15 && n < 20);
    if (last_q != 4'd15) begin
      total++;
      $error("FAIL align_timeout: observed q=%0d expected q=15", last_q);
    end
  endtask

  // One full period: d expected high cycles, optional duty write / en drop at sample index.
  task automatic run_period(input int d, input int wr_at, input logic [4:0] wr_val,
                            input int en_at, input int exp_cnt);
    for (int i = 0; i < 16; i++) begin
      if (i == wr_at) begin
        duty_in = wr_val;
        duty_wr = 1'b1;
      end
      if (i == en_at) en = 1'b0;
      step();
      duty_wr = 1'b0;
      chk("pwm", {7'd0, pwm_out}, {7'd0, (i < d)});
      chk("pstart", {7'd0, period_start}, {7'd0, (i == 0)});
      chk("busy", {7'd0, busy}, {7'd0, ((i < 15) || en)});
    end
    chk("period_cnt", period_cnt, exp_cnt[7:0]);
  endtask

  initial begin
    reset   = 1'b1;
    q_in    = 4'd0;
    duty_in = 5'd0;
    duty_wr = 1'b0;
    en      = 1'b0;
    last_q  = 4'd0;

    step();
    step();
    chk("rst_pwm", {7'd0, pwm_out}, 8'd0);
    chk("rst_pstart", {7'd0, period_start}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_cnt", period_cnt, 8'd0);
    reset = 1'b0;

    // Enable with duty 5, walk through ARM into RUN.
    duty_in = 5'd5;
    duty_wr = 1'b1;
    en      = 1'b1;
    step();
    duty_wr = 1'b0;
    chk("arm_entry_busy", {7'd0, busy}, 8'd1);
    align();

    run_period(5, 0, 5'd0, -1, 1);      // write 0 for next period
    run_period(0, 0, 5'd16, -1, 2);     // duty 0: pwm stuck low, pstart still pulses
    run_period(16, 0, 5'd20, -1, 3);    // duty 16: stuck high
    run_period(16, 0, 5'd3, -1, 4);     // 20 clamps to 16
    run_period(3, 6, 5'd12, -1, 5);     // mid-period write leaves current period alone
    run_period(12, 15, 5'd16, -1, 6);   // write on the wrap edge lands one period later
    run_period(12, -1, 5'd0, -1, 7);
    run_period(16, -1, 5'd0, 8, 8);     // en drop at q=8 finishes the period

    step();
    chk("stop_pwm", {7'd0, pwm_out}, 8'd0);
    chk("stop_pstart", {7'd0, period_start}, 8'd0);
    chk("stop_busy", {7'd0, busy}, 8'd0);
    chk("stop_cnt", period_cnt, 8'd8);

    // Re-enable: passes through ARM, duty_act reloads 16.
    en = 1'b1;
    step();
    chk("rearm_busy", {7'd0, busy}, 8'd1);
    chk("rearm_pwm", {7'd0, pwm_out}, 8'd0);
    align();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("pre_rst_pwm", {7'd0, pwm_out}, 8'd1);
      chk("pre_rst_pstart", {7'd0, period_start}, {7'd0, (i == 0)});
    end

    // Reset at q=4 mid-RUN.
    reset = 1'b1;
    step();
    chk("mid_rst_q", {4'd0, last_q}, 8'd4);
    chk("mid_rst_pwm", {7'd0, pwm_out}, 8'd0);
    chk("mid_rst_pstart", {7'd0, period_start}, 8'd0);
    chk("mid_rst_busy", {7'd0, busy}, 8'd0);
    chk("mid_rst_cnt", period_cnt, 8'd0);
    reset   = 1'b0;
    duty_in = 5'd7;
    duty_wr = 1'b1;
    step();
    duty_wr = 1'b0;
    chk("post_rst_busy", {7'd0, busy}, 8'd1);
    chk("post_rst_pwm", {7'd0, pwm_out}, 8'd0);
    align();

    // Saturation: period_cnt climbs to 255 and holds.
    for (int k = 1; k <= 260; k++) begin
      run_period(7, -1, 5'd0, -1, (k > 255) ? 255 : k);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
